// File: rtl/registrador_paralelo_serial.sv
// Parallel-in/serial-out shifter: loads a WIDTH-bit word and sends it one bit per clock.
// Latency: first bit on saida the cycle after the accepting edge; WIDTH cycles per word.
// Backpressure: pronto low while a word is in flight, high again in its last-bit cycle.
module registrador_paralelo_serial #(
    parameter int WIDTH        = 4,
    parameter bit MSB_PRIMEIRO = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] dado,
    input  logic             carrega,
    output logic             pronto,
    output logic             saida,
    output logic             valido_saida,
    output logic             fim
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(WIDTH - 1);

    typedef enum logic {
        OCIOSO   = 1'b0,
        ENVIANDO = 1'b1
    } estado_t;

    estado_t          estado, estado_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             valido_n, fim_n;
    logic             ultimo_bit;
    logic             aceita;

    // The last-bit cycle is the only point inside a word where a new load may land.
    assign ultimo_bit = (estado == ENVIANDO) && (cnt == ULTIMO);

    // Ready is combinational so a back-to-back load can be taken in the last-bit cycle;
    // it is held low for as long as reset is asserted.
    assign pronto = reset && ((estado == OCIOSO) || ultimo_bit);
    assign aceita = carrega && pronto;

    // Serial bit is taken straight from the output end of the shift register.
    // Shifting fills with zeros, so the register is empty (saida=0) whenever idle.
    assign saida = MSB_PRIMEIRO ? sr[WIDTH-1] : sr[0];

    // Next-state, next-shift-register and next-output decode.
    always_comb begin
        estado_n = estado;
        sr_n     = sr;
        cnt_n    = cnt;

        case (estado)
            OCIOSO: begin
                if (aceita) begin
                    estado_n = ENVIANDO;
                    sr_n     = dado;
                    cnt_n    = '0;
                end
            end
            ENVIANDO: begin
                if (cnt == ULTIMO) begin
                    if (aceita) begin
                        // Back-to-back: next word starts with no idle cycle.
                        estado_n = ENVIANDO;
                        sr_n     = dado;
                        cnt_n    = '0;
                    end else begin
                        estado_n = OCIOSO;
                        sr_n     = '0;
                        cnt_n    = '0;
                    end
                end else begin
                    if (MSB_PRIMEIRO) begin
                        sr_n = {sr[WIDTH-2:0], 1'b0};
                    end else begin
                        sr_n = {1'b0, sr[WIDTH-1:1]};
                    end
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                estado_n = OCIOSO;
                sr_n     = '0;
                cnt_n    = '0;
            end
        endcase

        valido_n = (estado_n == ENVIANDO);
        fim_n    = (estado_n == ENVIANDO) && (cnt_n == ULTIMO);
    end

    // State, shift register, counter and registered qualifiers; reset aborts any word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= OCIOSO;
            sr           <= '0;
            cnt          <= '0;
            valido_saida <= 1'b0;
            fim          <= 1'b0;
        end else begin
            estado       <= estado_n;
            sr           <= sr_n;
            cnt          <= cnt_n;
            valido_saida <= valido_n;
            fim          <= fim_n;
        end
    end

endmodule

// File: tb/tb_registrador_paralelo_serial.sv
module tb_registrador_paralelo_serial;

    logic       clock;
    logic       reset;
    logic [3:0] dado_m, dado_l;
    logic       carrega_m, carrega_l;
    logic       pronto_m, saida_m, valido_m, fim_m;
    logic       pronto_l, saida_l, valido_l, fim_l;

    int total = 0;
    int bad   = 0;
    bit exp_q[$];

    // receiving 4-stage serial-in chain fed by the MSB-first instance
    logic ra, rb, rc, rd;

    registrador_paralelo_serial #(.WIDTH(4), .MSB_PRIMEIRO(1'b1)) dut_msb (
        .clock(clock), .reset(reset), .dado(dado_m), .carrega(carrega_m),
        .pronto(pronto_m), .saida(saida_m), .valido_saida(valido_m), .fim(fim_m)
    );

    registrador_paralelo_serial #(.WIDTH(4), .MSB_PRIMEIRO(1'b0)) dut_lsb (
        .clock(clock), .reset(reset), .dado(dado_l), .carrega(carrega_l),
        .pronto(pronto_l), .saida(saida_l), .valido_saida(valido_l), .fim(fim_l)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            ra <= 1'b0; rb <= 1'b0; rc <= 1'b0; rd <= 1'b0;
        end else if (valido_m) begin
            ra <= saida_m; rb <= ra; rc <= rb; rd <= rc;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // expected serial order of a 4-bit word
    task automatic push_word(input logic [3:0] w, input bit msb);
        for (int i = 0; i < 4; i++) begin
            if (msb) exp_q.push_back(w[3-i]);
            else     exp_q.push_back(w[i]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; carrega_m = 1'b0; carrega_l = 1'b0; dado_m = '0; dado_l = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (pronto_m !== 1'b0) begin
                bad++; $display("FAIL reset_pronto_low got=%b want=0", pronto_m);
            end
        end
        reset = 1'b1;
        #1;
        total++;
        if ({saida_m, valido_m, fim_m, pronto_m} !== 4'b0001) begin
            bad++; $display("FAIL reset_release_msb got=%b want=0001", {saida_m, valido_m, fim_m, pronto_m});
        end
        total++;
        if ({saida_l, valido_l, fim_l, pronto_l} !== 4'b0001) begin
            bad++; $display("FAIL reset_release_lsb got=%b want=0001", {saida_l, valido_l, fim_l, pronto_l});
        end
        tick();
    endtask

    task automatic test_single_msb();
        bit e;
        dado_m = 4'b1011; carrega_m = 1'b1;
        push_word(4'b1011, 1'b1);
        tick();
        carrega_m = 1'b0;
        for (int c = 0; c < 6; c++) begin
            total++;
            if (c < 4) begin
                e = exp_q.pop_front();
                if ({valido_m, saida_m, fim_m, pronto_m} !== {1'b1, e, c == 3, c == 3}) begin
                    bad++; $display("FAIL single_msb c=%0d got(v,s,f,p)=%b want=%b", c,
                        {valido_m, saida_m, fim_m, pronto_m}, {1'b1, e, c == 3, c == 3});
                end
            end else begin
                if ({valido_m, saida_m, fim_m, pronto_m} !== 4'b0001) begin
                    bad++; $display("FAIL single_msb_idle c=%0d got=%b want=0001", c,
                        {valido_m, saida_m, fim_m, pronto_m});
                end
            end
            tick();
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL single_msb_left got=%0d want=0", exp_q.size());
        end
    endtask

    task automatic test_loopback();
        logic [3:0] words [2];
        words[0] = 4'b1011; words[1] = 4'b0110;
        for (int w = 0; w < 2; w++) begin
            dado_m = words[w]; carrega_m = 1'b1;
            push_word(words[w], 1'b1);
            tick();
            carrega_m = 1'b0;
            for (int c = 0; c < 4; c++) begin
                total++;
                if (valido_m !== 1'b1 || saida_m !== exp_q.pop_front()) begin
                    bad++; $display("FAIL loopback_bit w=%0d c=%0d got(v,s)=%b%b", w, c, valido_m, saida_m);
                end
                tick();
            end
            total++;
            if ({rd, rc, rb, ra} !== words[w]) begin
                bad++; $display("FAIL loopback_chain got=%b want=%b", {rd, rc, rb, ra}, words[w]);
            end
            tick();
        end
    endtask

    task automatic test_lsb();
        dado_l = 4'b1011; carrega_l = 1'b1;
        push_word(4'b1011, 1'b0);
        tick();
        carrega_l = 1'b0;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (c < 4) begin
                if ({valido_l, saida_l, fim_l} !== {1'b1, exp_q.pop_front(), c == 3}) begin
                    bad++; $display("FAIL lsb c=%0d got(v,s,f)=%b", c, {valido_l, saida_l, fim_l});
                end
            end else if ({valido_l, saida_l, pronto_l} !== 3'b001) begin
                bad++; $display("FAIL lsb_idle got=%b want=001", {valido_l, saida_l, pronto_l});
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int  fims = 0;
        bit  want_v, want_p, want_f, e;
        dado_m = 4'b1100; carrega_m = 1'b1;
        push_word(4'b1100, 1'b1);
        tick();
        dado_m = 4'b0011;
        for (int c = 0; c < 10; c++) begin
            want_v = (c < 8);
            want_f = (c == 3) || (c == 7);
            want_p = (c == 3) || (c == 7) || (c >= 8);
            if (c == 1) dado_m = 4'b1111;
            if (c == 2) dado_m = 4'b0011;
            if (c == 3) push_word(4'b0011, 1'b1);
            if (c == 4) carrega_m = 1'b0;
            e = want_v ? exp_q.pop_front() : 1'b0;
            if (fim_m === 1'b1) fims++;
            total++;
            if ({valido_m, saida_m, fim_m, pronto_m} !== {want_v, e, want_f, want_p}) begin
                bad++; $display("FAIL back_to_back c=%0d got(v,s,f,p)=%b want=%b", c,
                    {valido_m, saida_m, fim_m, pronto_m}, {want_v, e, want_f, want_p});
            end
            tick();
        end
        total++;
        if (fims != 2) begin
            bad++; $display("FAIL back_to_back_fim_count got=%0d want=2", fims);
        end
    endtask

    task automatic test_reset_mid_word();
        dado_m = 4'b1010; carrega_m = 1'b1;
        push_word(4'b1010, 1'b1);
        tick();
        carrega_m = 1'b0;
        for (int c = 0; c < 2; c++) begin
            total++;
            if (valido_m !== 1'b1 || saida_m !== exp_q.pop_front()) begin
                bad++; $display("FAIL midreset_pre c=%0d got(v,s)=%b%b", c, valido_m, saida_m);
            end
            if (c == 0) tick();
        end
        #3;
        reset = 1'b0;
        #1;
        total++;
        if ({saida_m, valido_m, fim_m, pronto_m} !== 4'b0000) begin
            bad++; $display("FAIL midreset_async got=%b want=0000", {saida_m, valido_m, fim_m, pronto_m});
        end
        exp_q.delete();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if ({saida_m, valido_m, fim_m, pronto_m} !== 4'b0001) begin
                bad++; $display("FAIL midreset_after c=%0d got=%b want=0001", c, {saida_m, valido_m, fim_m, pronto_m});
            end
            tick();
        end
        dado_m = 4'b0101; carrega_m = 1'b1;
        push_word(4'b0101, 1'b1);
        tick();
        carrega_m = 1'b0;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (c < 4) begin
                if ({valido_m, saida_m, fim_m} !== {1'b1, exp_q.pop_front(), c == 3}) begin
                    bad++; $display("FAIL midreset_next c=%0d got(v,s,f)=%b", c, {valido_m, saida_m, fim_m});
                end
            end else if ({valido_m, saida_m, pronto_m} !== 3'b001) begin
                bad++; $display("FAIL midreset_next_idle got=%b want=001", {valido_m, saida_m, pronto_m});
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_msb();
        test_loopback();
        test_lsb();
        test_back_to_back();
        test_reset_mid_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/registrador_paralelo_serial.md
Name: registrador_paralelo_serial

Overview:
- Parallel-in/serial-out shift register (serializer). It is the transmit end for the team's 4-stage serial-in shift register chain.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on a single serial line, with a bit-valid qualifier and an end-of-word pulse.
- Ordering is chosen so that a serial-in chain (entrada->A->B->C->D) clocked alongside it holds {D,C,B,A} == the loaded word WIDTH clocks after the first bit appears.

Parameters:
- WIDTH, 4, word width in bits. Legal range is WIDTH >= 2.
- MSB_PRIMEIRO, 1, selects the bit order.
  - 1: dado[WIDTH-1] is sent first.
  - 0: dado[0] is sent first.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset. reset=0 clears the block immediately, independent of clock.
- dado  input  WIDTH  parallel word to transmit. Sampled only on an accepted load.
- carrega  input  1  load request (valid). Qualified by pronto.
- pronto  output  1  block can accept a word this cycle (ready).
- saida  output  1  serial data bit.
- valido_saida  output  1  saida carries a valid bit this cycle.
- fim  output  1  one-cycle pulse marking the last bit of a word.

Behaviour:
- **Reset** (reset=0, asynchronous):
  - State goes to OCIOSO. Shift register and bit counter are cleared.
  - saida=0, valido_saida=0, fim=0, pronto=1 as soon as reset deasserts (pronto forced 0 while reset=0).
  - Reset mid-word aborts the transfer immediately. Remaining bits are discarded and never resumed.
- **Registers**: shift register sr[WIDTH-1:0]; counter cnt of $clog2(WIDTH) bits; state. All outputs are registered except pronto.
- **FSM state OCIOSO**:
  - pronto=1, valido_saida=0, saida=0.
  - An accepted load (carrega=1 & pronto=1) at edge k loads sr<=dado and cnt<=0, and moves the state to ENVIANDO.
  - carrega=0 keeps the state in OCIOSO.
- **FSM state ENVIANDO**:
  - Every edge shifts sr one position toward the output end and increments cnt.
  - valido_saida=1 for exactly WIDTH consecutive cycles.
  - pronto=0, except in the last-bit cycle (cnt==WIDTH-1), where pronto=1.
  - fim=1 only in the last-bit cycle.
- **Latency**: the first bit is on saida in the cycle after acceptance edge k, and is valid from edge k until edge k+1. Bit i of the sequence occupies cycle k+i for i=0..WIDTH-1.
- **Bit order**:
  - MSB_PRIMEIRO=1: sequence is dado[WIDTH-1], dado[WIDTH-2], ..., dado[0].
  - MSB_PRIMEIRO=0: sequence is reversed.
- **Back-to-back**:
  - carrega=1 during the last-bit cycle accepts the new word at that edge. Its first bit follows in the very next cycle with no gap. valido_saida stays 1, and fim pulses once per word.
  - Without a new load, the edge after the last bit returns the block to OCIOSO: valido_saida=0, saida=0.
- **carrega while busy**: carrega=1 while pronto=0 is ignored. dado is not sampled and the transfer in flight is unaffected.
- **dado stability**: dado changes after acceptance have no effect on the word being sent.
- **Counter wrap**: cnt never exceeds WIDTH-1. It resets to 0 on every accepted load.

Test Plan:
- **Reset**: hold reset=0 for 3 clocks, then release with carrega=0 -> saida=0, valido_saida=0, fim=0, pronto=1. Assert reset=0 mid-clock -> outputs clear without waiting for an edge.
- **Single word, MSB first**: WIDTH=4, dado=4'b1011, carrega pulsed 1 cycle -> saida 1,0,1,1 on the next 4 cycles, valido_saida=1 for exactly those 4 cycles, fim=1 only on the 4th, pronto=0 on cycles 1-3 and 1 on cycle 4, then idle.
- **Loopback to receiver**: feed saida into a 4-stage serial-in chain clocked with it, enabled by valido_saida, dado=4'b1011 -> after 4 shifts {D,C,B,A}=4'b1011. Repeat with dado=4'b0110 -> 4'b0110.
- **LSB first**: MSB_PRIMEIRO=0, dado=4'b1011 -> saida 1,1,0,1.
- **Back-to-back and busy loads**:
  - Load 4'b1100, then hold carrega=1 with dado=4'b0011 throughout -> load accepted only in the last-bit cycle. saida stream is 1,1,0,0,0,0,1,1 with no gap, and fim pulses exactly twice.
  - Changing dado to 4'b1111 during the first word does not alter its bits.
- **Reset mid-word**: dado=4'b1010 loaded, reset=0 after 2 bits -> remaining bits never appear, pronto=1 after release. Next load of 4'b0101 transmits 0,1,0,1 cleanly.
